// File: rtl/store_buffer_if.sv
// store_buffer_if: store request, memory write port and load-hazard signals of the store buffer.
// master = pipeline/memory environment side, slave = the store buffer itself.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Committed store from MEM
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_funct3;

    // Data-memory / IO write port
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_we;

    // Load hazard query
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_stall;

    // Status
    logic          misalign;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_funct3,
        input  st_ready,
        input  mem_valid, mem_addr, mem_din, mem_we,
        output mem_ready,
        output ld_valid, ld_addr,
        input  ld_stall,
        input  misalign, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3,
        output st_ready,
        output mem_valid, mem_addr, mem_din, mem_we,
        input  mem_ready,
        input  ld_valid, ld_addr,
        output ld_stall,
        output misalign, count
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: aligns committed SB/SH/SW stores into lane data + byte enables, queues them in a
// DEPTH-entry FIFO and drains the head to the data-memory write port over valid/ready.
// Build option STORE_FWD_EN: when defined, a load stalls only if a queued entry targets the
// same word; when undefined, any pending store stalls any load.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0]    FNC_SB    = 3'b000;
    localparam logic [2:0]    FNC_SH    = 3'b001;
    localparam logic [2:0]    FNC_SW    = 3'b010;
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    // Entry storage; contents are don't-care until written, so no reset
    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [31:0]   ent_din_q  [DEPTH];
    logic [3:0]    ent_we_q   [DEPTH];

    ptr_t          wr_ptr_q, wr_ptr_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          misalign_q, misalign_d;

    // Aligned view of the incoming store
    logic [1:0]    st_off;
    logic [AW-1:0] new_addr;
    logic [31:0]   new_din;
    logic [3:0]    new_we;
    logic          new_bad;

    logic          full, empty;
    logic          st_accept, enq, deq;
    logic          mem_valid_w;

    logic          unused_ld;

    assign st_off    = sb.st_addr[1:0];
    assign new_addr  = {sb.st_addr[AW-1:2], 2'b00};
    assign full      = (count_q == CountFull);
    assign empty     = (count_q == '0);
    assign mem_valid_w = !empty;
    // A rejected (misaligned/illegal) store still completes the handshake but is never queued
    assign st_accept = sb.st_valid && !full;
    assign enq       = st_accept && !new_bad;
    assign deq       = mem_valid_w && sb.mem_ready;
    assign unused_ld = ^sb.ld_addr;

    // Lane alignment and legality check of the incoming store
    always_comb begin
        new_din = '0;
        new_we  = '0;
        new_bad = 1'b0;
        case (sb.st_funct3)
            FNC_SB: begin
                new_din = {4{sb.st_data[7:0]}};
                new_we  = 4'b0001 << st_off;
            end
            FNC_SH: begin
                new_din = {2{sb.st_data[15:0]}};
                new_we  = 4'b0011 << st_off;
                new_bad = st_off[0];
            end
            FNC_SW: begin
                new_din = sb.st_data;
                new_we  = 4'b1111;
                new_bad = (st_off != 2'b00);
            end
            default: begin
                new_bad = 1'b1;
            end
        endcase
    end

    // Next-state for pointers, occupancy and the misalign pulse
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = st_accept && new_bad;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared asynchronously (also discards any in-flight drain)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Write the aligned store into the tail entry
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[wr_ptr_q] <= new_addr;
            ent_din_q[wr_ptr_q]  <= new_din;
            ent_we_q[wr_ptr_q]   <= new_we;
        end
    end

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             ld_hit;

    // Per-entry valid bits: set on enqueue, cleared on dequeue (never the same entry)
    always_comb begin
        vld_d = vld_q;
        if (deq) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (enq) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    // Entry valid bits, cleared with the rest of the control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Word-address match against every valid entry; a dequeuing head still matches
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (ent_addr_q[i][AW-1:2] == sb.ld_addr[AW-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end
`endif

    // Outputs: memory port from the registered head, zeroed while empty
    always_comb begin
        sb.st_ready  = !full;
        sb.mem_valid = mem_valid_w;
        sb.mem_addr  = mem_valid_w ? ent_addr_q[rd_ptr_q] : '0;
        sb.mem_din   = mem_valid_w ? ent_din_q[rd_ptr_q]  : '0;
        sb.mem_we    = mem_valid_w ? ent_we_q[rd_ptr_q]   : 4'b0000;
        sb.misalign  = misalign_q;
        sb.count     = count_q;
`ifdef STORE_FWD_EN
        sb.ld_stall  = sb.ld_valid && ld_hit;
`else
        sb.ld_stall  = sb.ld_valid && !empty;
`endif
    end
endmodule
